// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared constants and types for the SA output collector
package sa_pkg;
    localparam int SA_ROWS = 3;
    localparam int SA_COLS = 3;
    localparam int PSUM_W  = 20;
    localparam int OUT_W   = 8;
    localparam int ADDR_W  = 6;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef enum logic [1:0] {
        OC_IDLE = 2'd0,
        OC_RUN  = 2'd1,
        OC_DONE = 2'd2
    } oc_state_t;
endpackage

// File: rtl/sa_output_collector_if.sv
// rtl/sa_output_collector_if.sv - output-buffer write port of the collector
interface sa_output_collector_if;
    import sa_pkg::*;

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [SA_COLS*OUT_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/sa_requant.sv
// rtl/sa_requant.sv - combinational round/shift/ReLU/saturate of one partial sum
module sa_requant
    import sa_pkg::*;
(
    input  logic signed [PSUM_W-1:0] x,
    input  logic        [3:0]        shift,
    input  logic                     relu_en,
    output logic        [OUT_W-1:0]  y
);
    // One guard bit keeps the rounding add from overflowing before the shift.
    logic signed [PSUM_W:0] xe;
    logic signed [PSUM_W:0] rnd;
    logic signed [PSUM_W:0] r;

    always_comb begin
        xe  = {x[PSUM_W-1], x};
        rnd = xe;
        r   = xe;
        if (shift != 4'd0) begin
            rnd = xe + ((PSUM_W+1)'(1) << (shift - 4'd1));
            r   = rnd >>> shift;
        end
        if (relu_en && (r < 0)) begin
            r = '0;
        end
        if (r > INT8_MAX) begin
            y = OUT_W'(INT8_MAX);
        end else if (r < INT8_MIN) begin
            y = OUT_W'(INT8_MIN);
        end else begin
            y = r[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/sa_output_collector.sv
// rtl/sa_output_collector.sv - de-skews SA column sums, requantizes and writes rows
module sa_output_collector
    import sa_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic        [ADDR_W-1:0] out_baseaddr_i,
    input  logic        [ADDR_W-1:0] num_rows_i,
    input  logic        [3:0]        shift_i,
    input  logic                     relu_en_i,
    input  logic        [2:0]        col_valid_i,
    input  logic signed [PSUM_W-1:0] psum_1,
    input  logic signed [PSUM_W-1:0] psum_2,
    input  logic signed [PSUM_W-1:0] psum_3,
    sa_output_collector_if.master    wr,
    output logic                     is_OC_done_o,
    output logic                     skew_err_o
);
    oc_state_t state;

    logic                     v0_d1, v0_d2, v1_d1;
    logic signed [PSUM_W-1:0] p0_d1, p0_d2, p1_d1;

    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_rows;
    logic [3:0]        cfg_shift;
    logic              cfg_relu;
    logic [ADDR_W-1:0] row_cnt;

    logic [2:0] vld_vec;
    logic       aligned;
    logic       misaligned;

    logic signed [PSUM_W-1:0] rq_in  [SA_COLS];
    logic        [OUT_W-1:0]  rq_out [SA_COLS];

    // Column 0 waits two cycles and column 1 one cycle for column 2 of the same row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_d1 <= 1'b0;
            v0_d2 <= 1'b0;
            v1_d1 <= 1'b0;
            p0_d1 <= '0;
            p0_d2 <= '0;
            p1_d1 <= '0;
        end else begin
            v0_d1 <= col_valid_i[0];
            v0_d2 <= v0_d1;
            v1_d1 <= col_valid_i[1];
            p0_d1 <= psum_1;
            p0_d2 <= p0_d1;
            p1_d1 <= psum_2;
        end
    end

    assign vld_vec    = {col_valid_i[2], v1_d1, v0_d2};
    assign aligned    = (vld_vec == 3'b111);
    assign misaligned = (vld_vec != 3'b000) && !aligned;

    assign rq_in[0] = p0_d2;
    assign rq_in[1] = p1_d1;
    assign rq_in[2] = psum_3;

    for (genvar j = 0; j < SA_COLS; j++) begin : g_rq
        sa_requant u_rq (
            .x       (rq_in[j]),
            .shift   (cfg_shift),
            .relu_en (cfg_relu),
            .y       (rq_out[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= OC_IDLE;
            cfg_base     <= '0;
            cfg_rows     <= '0;
            cfg_shift    <= '0;
            cfg_relu     <= 1'b0;
            row_cnt      <= '0;
            wr.wr_en     <= 1'b0;
            wr.wr_addr   <= '0;
            wr.wr_data   <= '0;
            is_OC_done_o <= 1'b0;
            skew_err_o   <= 1'b0;
        end else begin
            wr.wr_en <= 1'b0;
            case (state)
                OC_IDLE, OC_DONE: begin
                    if (start_i) begin
                        cfg_base   <= out_baseaddr_i;
                        cfg_rows   <= num_rows_i;
                        cfg_shift  <= shift_i;
                        cfg_relu   <= relu_en_i;
                        row_cnt    <= '0;
                        skew_err_o <= 1'b0;
                        if (num_rows_i == '0) begin
                            state        <= OC_DONE;
                            is_OC_done_o <= 1'b1;
                        end else begin
                            state        <= OC_RUN;
                            is_OC_done_o <= 1'b0;
                        end
                    end
                end
                OC_RUN: begin
                    if (misaligned) begin
                        skew_err_o <= 1'b1;
                    end
                    if (aligned) begin
                        wr.wr_en   <= 1'b1;
                        wr.wr_addr <= cfg_base + row_cnt;
                        wr.wr_data <= {rq_out[2], rq_out[1], rq_out[0]};
                        row_cnt    <= row_cnt + 1'b1;
                        if (row_cnt == cfg_rows - 1'b1) begin
                            state        <= OC_DONE;
                            is_OC_done_o <= 1'b1;
                        end
                    end
                end
                default: state <= OC_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_output_collector.sv
// tb/tb_sa_output_collector.sv - randomized and directed bench with a row-level model
module tb_sa_output_collector;
    localparam int INF = 32'h7fffffff;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic [5:0]         out_baseaddr_i;
    logic [5:0]         num_rows_i;
    logic [3:0]         shift_i;
    logic               relu_en_i;
    logic [2:0]         col_valid_i;
    logic signed [19:0] psum_1, psum_2, psum_3;
    logic               is_OC_done_o;
    logic               skew_err_o;

    sa_output_collector_if wr_bus ();

    sa_output_collector dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .out_baseaddr_i (out_baseaddr_i),
        .num_rows_i     (num_rows_i),
        .shift_i        (shift_i),
        .relu_en_i      (relu_en_i),
        .col_valid_i    (col_valid_i),
        .psum_1         (psum_1),
        .psum_2         (psum_2),
        .psum_3         (psum_3),
        .wr             (wr_bus),
        .is_OC_done_o   (is_OC_done_o),
        .skew_err_o     (skew_err_o)
    );

    typedef struct {
        int         cyc;
        logic [5:0] addr;
        logic [23:0] data;
    } wr_t;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    // Row-level model: which writes must appear on which cycle, and from when done/err hold.
    wr_t eq[$];
    wr_t wlog[$];
    bit  active = 0;
    int  mbase, mrows, msh, mcount;
    bit  mrelu;
    int  done_from = INF;
    int  err_from  = INF;
    int  pbase;

    logic [2:0] sv [64];
    int         sp [64][3];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int mrq(int x, int sh, bit relu);
        int r;
        r = (sh > 0) ? ((x + (1 << (sh - 1))) >>> sh) : x;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic logic [23:0] mrow(int a, int b, int c);
        return {8'(mrq(c, msh, mrelu)), 8'(mrq(b, msh, mrelu)), 8'(mrq(a, msh, mrelu))};
    endfunction

    always @(negedge clk) begin
        bit exp_wr;
        exp_wr = (eq.size() > 0) && (eq[0].cyc == cyc);
        chk("wr_en", wr_bus.wr_en, exp_wr);
        if (exp_wr) begin
            chk("wr_addr", wr_bus.wr_addr, eq[0].addr);
            chk("wr_data", wr_bus.wr_data, eq[0].data);
            void'(eq.pop_front());
        end
        if (wr_bus.wr_en) wlog.push_back('{cyc, wr_bus.wr_addr, wr_bus.wr_data});
        chk("done", is_OC_done_o, cyc >= done_from);
        chk("skew_err", skew_err_o, cyc >= err_from);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int base, input int rows, input int sh, input bit relu);
        start_i        = 1'b1;
        out_baseaddr_i = 6'(base);
        num_rows_i     = 6'(rows);
        shift_i        = 4'(sh);
        relu_en_i      = relu;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        active    = 1;
        mbase     = base;
        mrows     = rows;
        msh       = sh;
        mrelu     = relu;
        mcount    = 0;
        err_from  = INF;
        done_from = (rows == 0) ? cyc : INF;
        wlog.delete();
    endtask

    task automatic begin_sched();
        pbase = cyc;
        for (int i = 0; i < 64; i++) begin
            sv[i] = 3'b000;
            sp[i] = '{0, 0, 0};
        end
    endtask

    // Column j of a row starting at slot e is presented at slot e+j; late pushes column 1 to e+2.
    task automatic add_row(input int e, input int a, input int b, input int c, input bit late);
        sv[e][0] = 1'b1;
        sp[e][0] = a;
        if (late) begin
            sv[e+2][1] = 1'b1;
            sp[e+2][1] = b;
        end else begin
            sv[e+1][1] = 1'b1;
            sp[e+1][1] = b;
        end
        sv[e+2][2] = 1'b1;
        sp[e+2][2] = c;
        if (active && mcount < mrows) begin
            if (late) begin
                if (err_from == INF) err_from = pbase + e + 3;
            end else begin
                eq.push_back('{pbase + e + 3, 6'(mbase + mcount), mrow(a, b, c)});
                mcount++;
                if (mcount == mrows) done_from = pbase + e + 3;
            end
        end
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            col_valid_i = sv[i];
            psum_1 = 20'(sp[i][0]);
            psum_2 = 20'(sp[i][1]);
            psum_3 = 20'(sp[i][2]);
            @(posedge clk);
            #1;
        end
        col_valid_i = 3'b000;
        psum_1 = '0;
        psum_2 = '0;
        psum_3 = '0;
    endtask

    function automatic int rnd_psum();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 600)) - 300;
            1:       return int'($urandom_range(0, 10000)) - 5000;
            2:       return int'($urandom_range(0, 1048575)) - 524288;
            default: return int'($urandom_range(0, 80000)) - 40000;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        out_baseaddr_i = '0;
        num_rows_i = '0;
        shift_i = '0;
        relu_en_i = 1'b0;
        col_valid_i = '0;
        psum_1 = '0;
        psum_2 = '0;
        psum_3 = '0;
        #50;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_wr_en", wr_bus.wr_en, 0);
        chk("rst_wr_addr", wr_bus.wr_addr, 0);
        chk("rst_wr_data", wr_bus.wr_data, 0);
        chk("rst_done", is_OC_done_o, 0);
        chk("rst_err", skew_err_o, 0);

        // Two back-to-back rows, pass-through requant
        do_start(9, 2, 0, 0);
        begin_sched();
        add_row(0, 10, 20, 30, 0);
        add_row(1, -5, 6, 7, 0);
        play(5);
        idle(2);
        chk("t1_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t1_addr0", wlog[0].addr, 9);
            chk("t1_data0", wlog[0].data, 24'h1E140A);
            chk("t1_addr1", wlog[1].addr, 10);
            chk("t1_data1", wlog[1].data, 24'h0706FB);
        end
        chk("t1_done", is_OC_done_o, 1);
        chk("t1_err", skew_err_o, 0);

        // Rounding shift, saturation, ReLU
        do_start(0, 1, 2, 0);
        begin_sched();
        add_row(0, 6, -6, 1000, 0);
        chk("t2_model", eq[0].data, 24'h7FFF02);
        play(4);
        idle(2);
        chk("t2a_data", (wlog.size() == 1) ? wlog[0].data : 24'hxxxxxx, 24'h7FFF02);
        do_start(1, 1, 2, 1);
        begin_sched();
        add_row(0, 6, -6, 1000, 0);
        play(4);
        idle(2);
        chk("t2b_data", (wlog.size() == 1) ? wlog[0].data : 24'hxxxxxx, 24'h7F0002);

        // Address wrap
        do_start(63, 2, 0, 0);
        begin_sched();
        add_row(0, 1, 1, 1, 0);
        add_row(1, 2, 2, 2, 0);
        play(5);
        idle(2);
        chk("t3_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t3_addr0", wlog[0].addr, 63);
            chk("t3_addr1", wlog[1].addr, 0);
        end

        // Late column 1 drops the row and flags skew
        do_start(12, 2, 0, 0);
        begin_sched();
        add_row(0, 9, 9, 9, 1);
        add_row(5, 4, 5, 6, 0);
        add_row(7, -1, -2, -3, 0);
        play(11);
        idle(2);
        chk("t4_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t4_addr0", wlog[0].addr, 12);
            chk("t4_data0", wlog[0].data, 24'h060504);
        end
        chk("t4_err", skew_err_o, 1);

        // Zero rows: done at once, later rows ignored
        do_start(5, 0, 0, 0);
        chk("t5_done_now", is_OC_done_o, 1);
        begin_sched();
        add_row(0, 1, 2, 3, 0);
        add_row(2, 4, 5, 6, 0);
        play(6);
        idle(2);
        chk("t5_nwr", wlog.size(), 0);

        // Reset in the middle of a run
        do_start(20, 3, 0, 0);
        begin_sched();
        add_row(0, 1, 2, 3, 0);
        add_row(4, 4, 5, 6, 0);
        add_row(8, 7, 8, 9, 0);
        play(6);
        chk("t6_nwr_before", wlog.size(), 1);
        eq.delete();
        active = 0;
        done_from = INF;
        err_from = INF;
        rst = 1'b1;
        #1;
        chk("t6_wr_en", wr_bus.wr_en, 0);
        chk("t6_wr_addr", wr_bus.wr_addr, 0);
        chk("t6_wr_data", wr_bus.wr_data, 0);
        chk("t6_done", is_OC_done_o, 0);
        idle(2);
        rst = 1'b0;
        wlog.delete();
        idle(3);
        chk("t6_nwr_after", wlog.size(), 0);
        do_start(30, 1, 1, 0);
        begin_sched();
        add_row(0, 3, 5, -3, 0);
        play(4);
        idle(2);
        chk("t6_new_addr", (wlog.size() == 1) ? wlog[0].addr : 6'hxx, 30);
        chk("t6_new_data", (wlog.size() == 1) ? wlog[0].data : 24'hxxxxxx, 24'hFF0302);

        // Randomized runs, restarting from DONE each time
        for (int it = 0; it < 30; it++) begin
            int e;
            int last_e;
            int nrows;
            int nsend;
            int sh;
            nrows = $urandom_range(1, 6);
            nsend = nrows + $urandom_range(0, 2);
            sh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 15);
            do_start($urandom_range(0, 63), nrows, sh, 1'($urandom_range(0, 1)));
            begin_sched();
            e = 0;
            last_e = 0;
            for (int r = 0; r < nsend; r++) begin
                add_row(e, rnd_psum(), rnd_psum(), rnd_psum(), 0);
                last_e = e;
                e += $urandom_range(1, 3);
            end
            play(last_e + 4);
            idle(2);
            chk("rnd_nwr", wlog.size(), nrows);
            chk("rnd_pending", eq.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
